// File: rtl/rom_port_arbiter.sv
// Two-port arbiter for the instruction ROM read port (IF fetch vs LS load), 1-cycle registered read data.
// Define ROM_ARB_RR_EN for round-robin conflict resolution; default is LS priority with an IF starvation guard.
module rom_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  output logic        o_if_misal,
  input  logic        i_ls_req,
  input  logic [31:0] i_ls_addr,
  output logic        o_ls_gnt,
  output logic        o_ls_rvalid,
  output logic [31:0] o_ls_rdata,
  output logic        o_ls_misal,
  output logic [31:0] o_rom_addr,
  input  logic [31:0] i_rom_data
);

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;

  logic r_last_gnt;
  logic w_if_wins_conflict;
  logic w_if_gnt;
  logic w_ls_gnt;

`ifdef ROM_ARB_RR_EN
  // Round-robin: on a conflict the port that did not win last time takes the grant.
  always_comb begin
    w_if_wins_conflict = (r_last_gnt == GNT_LS);
  end
`else
  logic [CNT_W-1:0] r_wait_cnt;

  always_comb begin
    w_if_wins_conflict = (r_wait_cnt == CNT_W'(STARVE_LIMIT));
  end

  // Counts consecutive cycles IF was left waiting; saturates so IF keeps winning until served.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
    end else if (!i_if_req || w_if_gnt) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != CNT_W'(STARVE_LIMIT)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    w_if_gnt = 1'b0;
    w_ls_gnt = 1'b0;
    if (!i_rst) begin
      w_if_gnt = i_if_req && (!i_ls_req || w_if_wins_conflict);
      w_ls_gnt = i_ls_req && !w_if_gnt;
    end
  end

  always_comb begin
    o_rom_addr = '0;
    if (w_if_gnt) begin
      o_rom_addr = i_if_addr;
    end else if (w_ls_gnt) begin
      o_rom_addr = i_ls_addr;
    end
  end

  assign o_if_gnt = w_if_gnt;
  assign o_ls_gnt = w_ls_gnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_gnt <= GNT_LS;
    end else if (w_if_gnt) begin
      r_last_gnt <= GNT_IF;
    end else if (w_ls_gnt) begin
      r_last_gnt <= GNT_LS;
    end
  end

  // The ROM ignores the low address bits, so the aligned word is captured and misalignment is flagged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_if_rvalid <= 1'b0;
      o_if_rdata  <= '0;
      o_if_misal  <= 1'b0;
      o_ls_rvalid <= 1'b0;
      o_ls_rdata  <= '0;
      o_ls_misal  <= 1'b0;
    end else begin
      o_if_rvalid <= w_if_gnt;
      o_if_misal  <= w_if_gnt && (i_if_addr[1:0] != 2'b00);
      o_ls_rvalid <= w_ls_gnt;
      o_ls_misal  <= w_ls_gnt && (i_ls_addr[1:0] != 2'b00);
      if (w_if_gnt) begin
        o_if_rdata <= i_rom_data;
      end
      if (w_ls_gnt) begin
        o_ls_rdata <= i_rom_data;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Randomized self-checking bench for rom_port_arbiter against a cycle-level reference model.
// Honours ROM_ARB_RR_EN so the same bench follows either arbitration build.
module tb_rom_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W        = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifReq = 1'b0, lsReq = 1'b0;
  logic [31:0] ifAddr = '0, lsAddr = '0;
  logic        ifGnt, ifRvalid, ifMisal, lsGnt, lsRvalid, lsMisal;
  logic [31:0] ifRdata, lsRdata, romAddr, romData;

  logic [31:0] rom [0:4095];

  int checksTotal  = 0;
  int checksPassed = 0;

  // Reference model state: what the registered outputs must show after the coming edge.
  bit          mIfValid = 0, mLsValid = 0, mIfMisal = 0, mLsMisal = 0;
  logic [31:0] mIfData = '0, mLsData = '0;
  int          mDenied = 0;
  bit          mLastLs = 1;
  bit          gIfWon = 0, gLsWon = 0;

  always #5 clk = ~clk;

  assign romData = rom[romAddr[13:2]];

  rom_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(ifReq), .i_if_addr(ifAddr), .o_if_gnt(ifGnt),
    .o_if_rvalid(ifRvalid), .o_if_rdata(ifRdata), .o_if_misal(ifMisal),
    .i_ls_req(lsReq), .i_ls_addr(lsAddr), .o_ls_gnt(lsGnt),
    .o_ls_rvalid(lsRvalid), .o_ls_rdata(lsRdata), .o_ls_misal(lsMisal),
    .o_rom_addr(romAddr), .i_rom_data(romData)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  task automatic resetModel();
    mIfValid = 0; mLsValid = 0; mIfMisal = 0; mLsMisal = 0;
    mIfData = '0; mLsData = '0; mDenied = 0; mLastLs = 1;
  endtask

  task automatic checkRegisters();
    checkOutput("if_rvalid", ifRvalid, mIfValid);
    checkOutput("if_rdata",  ifRdata,  mIfData);
    checkOutput("if_misal",  ifMisal,  mIfMisal);
    checkOutput("ls_rvalid", lsRvalid, mLsValid);
    checkOutput("ls_rdata",  lsRdata,  mLsData);
    checkOutput("ls_misal",  lsMisal,  mLsMisal);
  endtask

  // One bus cycle: drive at the falling edge, check, then advance the model across the next rising edge.
  task automatic applyStimulus(input bit iReq, input logic [31:0] iAddr, input bit lReq, input logic [31:0] lAddr);
    bit ifWins, lsWins, ifFavoured;
    logic [31:0] expAddr, a;
    @(negedge clk);
    ifReq = iReq; ifAddr = iAddr; lsReq = lReq; lsAddr = lAddr;
    #1;
    checkRegisters();
`ifdef ROM_ARB_RR_EN
    ifFavoured = mLastLs;
`else
    ifFavoured = (mDenied >= STARVE_LIMIT);
`endif
    ifWins  = iReq && (!lReq || ifFavoured);
    lsWins  = lReq && !ifWins;
    expAddr = ifWins ? iAddr : (lsWins ? lAddr : 32'h0);
    checkOutput("if_gnt",   ifGnt,   ifWins);
    checkOutput("ls_gnt",   lsGnt,   lsWins);
    checkOutput("rom_addr", romAddr, expAddr);
    mIfValid = ifWins; mLsValid = lsWins;
    mIfMisal = ifWins && (iAddr % 4 != 0);
    mLsMisal = lsWins && (lAddr % 4 != 0);
    if (ifWins) begin a = iAddr; mIfData = rom[a[13:2]]; end
    if (lsWins) begin a = lAddr; mLsData = rom[a[13:2]]; end
    if (ifWins) mLastLs = 0;
    else if (lsWins) mLastLs = 1;
    if (!iReq || ifWins) mDenied = 0;
    else if (mDenied < STARVE_LIMIT) mDenied++;
    gIfWon = ifWins; gLsWon = lsWins;
  endtask

  initial begin
    bit pIf, pLs;
    logic [31:0] pIfAddr, pLsAddr;
    for (int i = 0; i < 4096; i++) rom[i] = $urandom;
    rom[4] = 32'hDEADBEEF;
    rom[8] = 32'hCAFEF00D;

    // Reset held with both requesters active: no grants may appear.
    ifReq = 1; lsReq = 1; ifAddr = 32'h100; lsAddr = 32'h200;
    repeat (2) begin
      @(negedge clk); #1;
      checkOutput("rst_if_gnt", ifGnt, 0);
      checkOutput("rst_ls_gnt", lsGnt, 0);
    end
    @(negedge clk);
    rst = 0; ifReq = 0; lsReq = 0;
    #1;
    checkRegisters();

    // Single IF fetch of word 4.
    applyStimulus(1, 32'h10, 0, 32'h0);
    applyStimulus(0, 32'h0, 0, 32'h0);
    checkOutput("if_word4", ifRdata, 32'hDEADBEEF);

    // Continuous conflict: starvation guard (or alternation in round-robin builds).
    for (int i = 0; i < 15; i++) applyStimulus(1, 32'h40 + 4 * i, 1, 32'h80 + 4 * i);
    applyStimulus(0, 32'h0, 0, 32'h0);

    // Misaligned load returns the aligned word 8.
    applyStimulus(0, 32'h0, 1, 32'h22);
    applyStimulus(0, 32'h0, 0, 32'h0);
    checkOutput("ls_word8", lsRdata, 32'hCAFEF00D);
    applyStimulus(0, 32'h0, 0, 32'h0);

    // Randomized traffic; a pending request usually holds its address until granted.
    pIf = 0; pLs = 0; pIfAddr = '0; pLsAddr = '0;
    for (int i = 0; i < 400; i++) begin
      if (!(pIf && !gIfWon && $urandom_range(0, 4) != 0)) begin
        pIf = ($urandom_range(0, 2) != 0); pIfAddr = $urandom;
      end
      if (!(pLs && !gLsWon && $urandom_range(0, 4) != 0)) begin
        pLs = ($urandom_range(0, 2) != 0); pLsAddr = $urandom;
      end
      applyStimulus(pIf, pIfAddr, pLs, pLsAddr);
    end
    applyStimulus(0, 32'h0, 0, 32'h0);

    // Reset lands between a load grant and its response edge: the response must be dropped.
    applyStimulus(0, 32'h0, 1, 32'h44);
    #2;
    rst = 1;
    #1;
    checkOutput("midrst_ls_gnt", lsGnt, 0);
    lsReq = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    resetModel();
    checkOutput("midrst_ls_rvalid", lsRvalid, 0);
    checkOutput("midrst_ls_rdata",  lsRdata,  0);
    applyStimulus(0, 32'h0, 0, 32'h0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
